// File: rtl/core_pkg.sv
// Shared FPU definitions for the core: op encodings, pipeline latencies and the
// layout of one in-flight scoreboard entry.
package core_pkg;

  typedef enum logic [2:0] {
    FPU_ADD  = 3'd0,
    FPU_SUB  = 3'd1,
    FPU_MUL  = 3'd2,
    FPU_DIV  = 3'd3,
    FPU_SQRT = 3'd4,
    FPU_CMP  = 3'd5,
    FPU_CVT  = 3'd6,
    FPU_MV   = 3'd7
  } fpu_op_e;

  localparam int LAT_ADD  = 3;
  localparam int LAT_SUB  = 3;
  localparam int LAT_MUL  = 4;
  localparam int LAT_DIV  = 12;
  localparam int LAT_SQRT = 16;

  localparam int SB_REG_W = 6;
  localparam int SB_CNT_W = 5;

  typedef struct packed {
    logic                valid;
    logic [SB_REG_W-1:0] rd;
    logic [SB_CNT_W-1:0] count;
    logic                is_div;
  } sb_entry_t;

  // Ops with latency 0 finish inside EX and are never tracked.
  function automatic logic [SB_CNT_W-1:0] fpu_latency(input logic [2:0] op);
    case (op)
      FPU_ADD:  return SB_CNT_W'(LAT_ADD);
      FPU_SUB:  return SB_CNT_W'(LAT_SUB);
      FPU_MUL:  return SB_CNT_W'(LAT_MUL);
      FPU_DIV:  return SB_CNT_W'(LAT_DIV);
      FPU_SQRT: return SB_CNT_W'(LAT_SQRT);
      default:  return '0;
    endcase
  endfunction

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == FPU_DIV) || (op == FPU_SQRT);
  endfunction

endpackage

// File: rtl/fpu_scoreboard.sv
// In-flight FPU result tracker: one countdown entry per outstanding multi-cycle op,
// with dependency, capacity and divider-occupancy queries for the instruction in ID.
module fpu_scoreboard
  import core_pkg::*;
#(
  parameter int REGFILE_LEN  = 6,
  parameter int FPU_OP_WIDTH = 3,
  parameter int SB_DEPTH     = 4,
  parameter int CNT_WIDTH    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REGFILE_LEN-1:0]  id_rs1,
  input  logic [REGFILE_LEN-1:0]  id_rs2,
  input  logic                    id_rs1_used,
  input  logic                    id_rs2_used,
  input  logic [REGFILE_LEN-1:0]  id_rd,
  input  logic                    id_rd_we,
  input  logic [FPU_OP_WIDTH-1:0] id_fpu_op,
  input  logic                    issue,
  input  logic                    freeze,
  output logic                    raw_hit,
  output logic                    waw_hit,
  output logic                    full,
  output logic                    div_busy,
  output logic                    busy
);

  localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

  sb_entry_t            entries [SB_DEPTH];
  logic [SB_DEPTH-1:0]  alloc_sel;
  logic [CNT_WIDTH-1:0] id_lat;

  assign id_lat = CNT_WIDTH'(fpu_latency(id_fpu_op));

  function automatic logic src_match(input logic used,
                                     input logic [REGFILE_LEN-1:0] src,
                                     input logic [REGFILE_LEN-1:0] rd);
    return used && (src != '0) && (src == rd);
  endfunction

  // An entry in its final cycle forwards its result, so it no longer blocks readers.
  always_comb begin
    raw_hit   = 1'b0;
    waw_hit   = 1'b0;
    full      = 1'b1;
    div_busy  = 1'b0;
    busy      = 1'b0;
    alloc_sel = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (entries[i].valid) begin
        busy = 1'b1;
        if ((entries[i].count > CNT_ONE) &&
            (src_match(id_rs1_used, id_rs1, entries[i].rd) ||
             src_match(id_rs2_used, id_rs2, entries[i].rd)))
          raw_hit = 1'b1;
        if (id_rd_we && (id_rd == entries[i].rd) && (entries[i].count > id_lat))
          waw_hit = 1'b1;
        if (entries[i].is_div)
          div_busy = 1'b1;
      end else begin
        full = 1'b0;
        if (alloc_sel == '0)
          alloc_sel[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SB_DEPTH; i++)
        entries[i] <= '0;
    end else begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (issue && alloc_sel[i]) begin
          entries[i].valid  <= 1'b1;
          entries[i].rd     <= id_rd;
          entries[i].count  <= id_lat;
          entries[i].is_div <= is_long_op(id_fpu_op);
        end else if (!freeze && entries[i].valid) begin
          if (entries[i].count == CNT_ONE)
            entries[i].valid <= 1'b0;
          entries[i].count <= entries[i].count - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline interlock generator: combines load-use, FPU scoreboard, memory wait and
// branch redirect conditions into per-stage stall and flush controls.
module hazard_unit
  import core_pkg::*;
#(
  parameter int REGFILE_LEN  = 6,
  parameter int FPU_OP_WIDTH = 3,
  parameter int SB_DEPTH     = 4,
  parameter int CNT_WIDTH    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [REGFILE_LEN-1:0]  id_rs1,
  input  logic [REGFILE_LEN-1:0]  id_rs2,
  input  logic                    id_rs1_used,
  input  logic                    id_rs2_used,
  input  logic [REGFILE_LEN-1:0]  id_rd,
  input  logic                    id_rd_we,
  input  logic                    id_is_fpu,
  input  logic [FPU_OP_WIDTH-1:0] id_fpu_op,
  input  logic                    ex_is_load,
  input  logic [REGFILE_LEN-1:0]  ex_rd,
  input  logic                    ex_rd_we,
  input  logic                    branch_taken,
  input  logic                    mem_busy,
  output logic                    pc_stall,
  output logic                    if_id_stall,
  output logic                    id_ex_stall,
  output logic                    ex_mem_stall,
  output logic                    mem_wb_stall,
  output logic                    if_id_flush,
  output logic                    id_ex_flush,
  output logic                    fpu_busy
);

  logic raw_hit, waw_hit, sb_full, div_busy, sb_busy;
  logic tracked, load_use, sb_struct, id_hold, issue;

  assign tracked   = id_is_fpu && (fpu_latency(id_fpu_op) != '0);
  assign load_use  = ex_is_load && ex_rd_we && (ex_rd != '0) &&
                     ((id_rs1_used && (id_rs1 == ex_rd)) ||
                      (id_rs2_used && (id_rs2 == ex_rd)));
  assign sb_struct = tracked && (sb_full || (is_long_op(id_fpu_op) && div_busy));
  assign id_hold   = id_valid && !branch_taken &&
                     (load_use || raw_hit || waw_hit || sb_struct);
  assign issue     = !rst && id_valid && tracked && !mem_busy && !branch_taken && !id_hold;

  fpu_scoreboard #(
    .REGFILE_LEN (REGFILE_LEN),
    .FPU_OP_WIDTH(FPU_OP_WIDTH),
    .SB_DEPTH    (SB_DEPTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .id_rd      (id_rd),
    .id_rd_we   (id_rd_we),
    .id_fpu_op  (id_fpu_op),
    .issue      (issue),
    .freeze     (mem_busy),
    .raw_hit    (raw_hit),
    .waw_hit    (waw_hit),
    .full       (sb_full),
    .div_busy   (div_busy),
    .busy       (sb_busy)
  );

  // A memory wait freezes the whole pipe; a redirect outranks any hazard held in ID.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    fpu_busy     = 1'b0;
    if (!rst) begin
      fpu_busy = sb_busy;
      if (mem_busy) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_stall = 1'b1;
      end else if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (id_hold) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline interlock generator for the five-stage core. It produces the per-stage stall and flush controls (`pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`, `mem_wb_stall`) that the core bench currently ties to 0. Inputs come from the ID, EX and memory stages. It detects load-use hazards, multi-cycle FPU RAW/WAW/structural hazards (via an internal scoreboard), data-memory wait states and taken-branch redirects. Its outputs drive the PC register and the pipeline registers directly.

## Interface
Parameters
- `REGFILE_LEN`, 6: register address width. Addresses 0–31 are integer registers, 32–63 are FP registers. Register 0 is hard-wired zero.
- `FPU_OP_WIDTH`, 3: FPU opcode width.
- `SB_DEPTH`, 4: number of in-flight FPU scoreboard entries.
- `CNT_WIDTH`, 5: latency counter width.

Ports (one clock; reset is synchronous and active-high)
- `clk` in 1: core clock, rising edge.
- `rst` in 1: synchronous active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` in REGFILE_LEN: ID source registers.
- `id_rs1_used`, `id_rs2_used` in 1: source actually read.
- `id_rd` in REGFILE_LEN; `id_rd_we` in 1: ID destination.
- `id_is_fpu` in 1; `id_fpu_op` in FPU_OP_WIDTH: ID instruction is an FPU op.
- `ex_is_load` in 1; `ex_rd` in REGFILE_LEN; `ex_rd_we` in 1: EX-stage load destination.
- `branch_taken` in 1: EX resolved a taken branch or jump this cycle.
- `mem_busy` in 1: data memory not ready.
- `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`, `mem_wb_stall` out 1 each: hold the named register.
- `if_id_flush`, `id_ex_flush` out 1 each: load a bubble into the named register.
- `fpu_busy` out 1: any scoreboard entry valid.

## Operation
- FPU latency by op: ADD=0 → 3, SUB=1 → 3, MUL=2 → 4, DIV=3 → 12, SQRT=4 → 16. CMP/CVT/MV (5–7) have latency 0. Latency-0 ops are not tracked; they use normal forwarding.
- Match rule: a source matches register r only when it is used, r≠0, and the addresses are equal.
- `freeze` = `mem_busy`.
- `load_use` = `ex_is_load` & `ex_rd_we` & (an ID source matches `ex_rd`).
- `sb_raw`: an ID source matches the rd of any valid entry.
- `sb_waw`: `id_rd_we` and `id_rd` equals a valid entry's rd with count > latency(`id_fpu_op`).
- `sb_struct`: the ID op is tracked and either all entries are valid, or the op is DIV/SQRT while a DIV/SQRT entry is valid.
- `id_hold` = `id_valid` & !`branch_taken` & (`load_use` | `sb_raw` | `sb_waw` | `sb_struct`).
- Output priority:
  - `freeze`: all five stalls = 1, both flushes = 0.
  - Else if `branch_taken`: both flushes = 1, all stalls = 0. The redirect wins over any ID hazard.
  - Else if `id_hold`: `pc_stall` = 1, `if_id_stall` = 1, `id_ex_flush` = 1. All other outputs 0.
  - Else all outputs 0.
- Issue condition: `id_valid` & tracked op & !`freeze` & !`branch_taken` & !`id_hold`. On issue, allocate the lowest-index entry that was free at the start of the cycle, with {valid, rd=`id_rd`, count=latency, is_div}.
- Each non-freeze cycle, every valid entry's count decrements. An entry whose count is 1 becomes invalid at that edge. Counts hold while `freeze`.
- Free and allocate in the same cycle are both applied. A slot freed this cycle is not reused until the next cycle.
- `branch_taken` never clears the scoreboard, because issued ops are older than the branch.

## Timing
- All outputs are combinational from the inputs and scoreboard state; there is no added latency.
- Scoreboard state updates on the rising edge.
- While `rst` is high: every output = 0, and at the edge all entries are cleared. Reset mid-operation discards in-flight entries.
- An entry issued at edge N blocks dependents in ID for cycles N+1 … N+L−1 (count L..2). The dependent issues in cycle N+L.
- `fpu_busy` is high from the cycle after issue until the cycle after the last entry frees.
- Load-use hazards always insert exactly one bubble when there is no freeze.

## Structure
- `core_pkg`:
  - FPU op encodings
  - latency constants `LAT_ADD`, `LAT_SUB`, `LAT_MUL`, `LAT_DIV`, `LAT_SQRT`
  - `fpu_latency()` function
  - scoreboard entry typedef
- Sub-module `fpu_scoreboard`: holds the entries, counters, allocate/free logic and match outputs (`raw_hit`, `waw_hit`, `full`, `div_busy`).
- `hazard_unit`: holds the load-use logic and the priority mux.

## Test plan
- Load-use: EX=`lw` rd=5; ID reads rs1=5 → one cycle with `pc_stall`=`if_id_stall`=`id_ex_flush`=1, then all 0. Repeat with rd=0 → no stall.
- FMUL f33 issued, followed by FADD reading f33 → 3 stall cycles, then issue in cycle 4. `fpu_busy` falls after the entry frees.
- FDIV in flight, then FSQRT in ID → structural stall until the FDIV entry frees. Also fill 4 FADDs to distinct rd; the 5th tracked op stalls until a slot frees.
- `branch_taken` while ID has a load-use hazard → flushes = 1, stalls = 0. The ID FPU op is not allocated (`fpu_busy` unchanged).
- `mem_busy` held 5 cycles during a FDIV countdown → all stalls = 1 and the count frozen. Dependent release is delayed by exactly 5 cycles.
- Assert `rst` with 2 valid entries → all outputs 0. Next cycle `fpu_busy`=0 and a dependent issues without stall.
